piso_stream: RTL and testbench
==============================

Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out shifter and successor to the basic 4-bit PISO.
- Accepts WIDTH-bit words on a valid/ready load handshake and holds one word in a buffer while the current word shifts, so back-to-back words serialise with no gap.
- Emits bits on a serial valid/enable handshake with a last-bit flag and compile-time bit order.
- Sits between a parallel producer (register file, counter) and a bit-serial consumer (line driver, serial TX).

Parameters:
- WIDTH, 4, parallel word width in bits; legal range 2..32.
- MSB_FIRST, 0, 0 = bit 0 shifted out first, 1 = bit WIDTH-1 shifted out first.

Ports:
- Clock  in  1  rising-edge clock for all state.
- Clear  in  1  asynchronous, active-high reset for all state.
- Load  in  1  producer valid; Data_In is taken when Load and Ready are both 1 at a rising edge.
- Data_In  in  WIDTH  parallel word.
- Ready  out  1  holding buffer is empty, so a word can be accepted.
- Shift_En  in  1  consumer accepts the current bit; SO advances when SO_Valid and Shift_En are both 1 at an edge.
- SO  out  1  serial data; forced to 0 when SO_Valid is 0.
- SO_Valid  out  1  the shifter holds a word and SO is meaningful.
- SO_Last  out  1  SO carries the final bit of the word (SO_Valid and bit count = WIDTH-1).
- Busy  out  1  shifter or holding buffer is occupied.

Behaviour:
- Clear=1 takes effect immediately, independent of Clock:
  - shifter, holding buffer and bit counter are emptied or zeroed;
  - SO=0, SO_Valid=0, SO_Last=0, Busy=0, Ready=1;
  - any word in flight is discarded with no partial output afterwards.
- Outputs are registered, or decoded from registers only, with one exception: Ready = !hold_full.
- Shifter states:
  - IDLE: SO_Valid=0.
  - SHIFT: SO_Valid=1; counter cnt runs 0..WIDTH-1; cnt width is clog2(WIDTH).
- "Bit taken" means SHIFT, Shift_En=1 and cnt=WIDTH-1 at the same edge.
- Accept rule: a word is accepted at an edge when Load and Ready are both 1.
  - Shifter in IDLE, or last bit taken at this edge: the accepted word loads straight into the shifter with cnt=0 and state SHIFT. Its first bit is on SO right after that edge (latency 1 clock from the accepting edge).
  - Otherwise the word goes into the holding buffer and hold_full is set.
- Advance rule: in SHIFT with Shift_En=1:
  - if cnt < WIDTH-1: cnt increments, and the shifter moves right when MSB_FIRST=0 or left when MSB_FIRST=1;
  - if the last bit is taken:
    - holding buffer full: the buffered word moves into the shifter with cnt=0, hold_full clears, state stays SHIFT (gapless);
    - holding buffer empty with an accept at the same edge: the new word loads directly;
    - otherwise the state goes to IDLE.
- Shift_En=0 in SHIFT freezes SO, cnt and SO_Last. Loading into an empty holding buffer is still allowed.
- Load=1 while Ready=0 is ignored, and Data_In is not sampled.
- Busy = SO_Valid | hold_full.
- Throughput: one bit per clock when Shift_En is held at 1, and WIDTH clocks per word.

Decomposition:
- Package piso_pkg holds:
  - state enum {PISO_IDLE, PISO_SHIFT};
  - a localparam helper function for the counter width, clog2(WIDTH);
  - legal WIDTH bounds, checked by an elaboration-time assertion.
- Sub-module piso_hold_buf: one-entry WIDTH-bit buffer with async clear, a write port, a take port, and full/empty flags.
- piso_stream contains the shifter, counter, state machine and output decode.

Test Plan:
- Reset: assert Clear for 3 clocks, then release mid-cycle -> SO=0, SO_Valid=0, SO_Last=0, Busy=0 and Ready=1 immediately on assertion; no activity until the first Load.
- WIDTH=4, MSB_FIRST=0, Shift_En=1, one Load of 4'b1001 -> over the next 4 clocks SO=1,0,0,1 with SO_Valid=1, SO_Last=1 on the 4th bit only, then IDLE and Busy=0.
- WIDTH=4, MSB_FIRST=1, Load 4'b0110 and then 4'b1001 on consecutive clocks -> Ready drops to 0 after the second accept; SO=0,1,1,0,1,0,0,1 over 8 consecutive clocks with no SO_Valid gap; SO_Last on bits 4 and 8.
- Backpressure: Load 4'b1100 with MSB_FIRST=0 and Shift_En=0 for 5 clocks after bit 1 -> SO holds 0 and cnt holds while stalled; after Shift_En=1 the remaining bits are 0,1,1; a second Load in the stall fills the buffer and Ready=0.
- Mid-word Clear: after 2 of 4 bits, with the holding buffer full, pulse Clear for 1 clock -> SO_Valid=0 and Ready=1 immediately; neither the remainder nor the buffered word is ever output; a new Load of 4'b0001 then shifts out cleanly.
- WIDTH=8 regression: 16 random words with random Shift_En stalls -> a scoreboard reassembles every word exactly, in order, with SO_Last on every 8th accepted bit.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_stream serialiser.
// Holds the shifter state encoding, WIDTH bounds and counter sizing.
package piso_pkg;

    typedef enum logic {
        PISO_IDLE,
        PISO_SHIFT
    } piso_state_t;

    localparam int PISO_WIDTH_MIN = 2;
    localparam int PISO_WIDTH_MAX = 32;

    function automatic int piso_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding buffer that parks the next word while the current one shifts.
// Writes are only issued when empty and takes only when full, so they never collide.
module piso_hold_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             take,
    output logic [WIDTH-1:0] data,
    output logic             full,
    output logic             empty
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data <= '0;
            full <= 1'b0;
        end else if (wr) begin
            data <= wr_data;
            full <= 1'b1;
        end else if (take) begin
            full <= 1'b0;
        end
    end

    assign empty = ~full;

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with a one-word holding buffer.
// Back-to-back words serialise gaplessly; bit order is fixed by MSB_FIRST.
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data_In,
    output logic             Ready,
    input  logic             Shift_En,
    output logic             SO,
    output logic             SO_Valid,
    output logic             SO_Last,
    output logic             Busy
);

    localparam int            CW       = piso_cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < PISO_WIDTH_MIN || WIDTH > PISO_WIDTH_MAX) begin : g_width_check
        $error("piso_stream: WIDTH must lie in 2..32");
    end

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    piso_state_t      state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             hold_empty;

    logic             shifting;
    logic             last_take;
    logic             accept;
    logic             direct;
    logic             hold_wr;
    logic             hold_take;

    assign shifting  = (state == PISO_SHIFT);
    assign last_take = shifting && Shift_En && (cnt == CNT_LAST);
    assign accept    = Load && hold_empty;
    assign direct    = accept && (!shifting || last_take);
    assign hold_wr   = accept && !direct;
    assign hold_take = last_take && hold_full;

    piso_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk    (Clock),
        .clr    (Clear),
        .wr     (hold_wr),
        .wr_data(Data_In),
        .take   (hold_take),
        .data   (hold_data),
        .full   (hold_full),
        .empty  (hold_empty)
    );

    // Buffered word wins over a direct load: a direct load is only possible when the buffer is empty.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state <= PISO_IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else if (hold_take) begin
            state <= PISO_SHIFT;
            sreg  <= hold_data;
            cnt   <= '0;
        end else if (direct) begin
            state <= PISO_SHIFT;
            sreg  <= Data_In;
            cnt   <= '0;
        end else if (last_take) begin
            state <= PISO_IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else if (shifting && Shift_En) begin
            sreg  <= shift_word(sreg);
            cnt   <= cnt + CW'(1);
        end
    end

    assign SO_Valid = shifting;
    assign SO       = shifting & out_bit(sreg);
    assign SO_Last  = shifting && (cnt == CNT_LAST);
    assign Busy     = shifting | hold_full;
    assign Ready    = hold_empty;

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: three instances (4-bit LSB-first, 4-bit MSB-first, 8-bit LSB-first)
// checked every cycle against a word-queue model, plus literal sequences and a word scoreboard.
module tb_piso_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       Clear = 1'b1;
    logic [2:0] ld    = '0;
    logic [2:0] en    = '0;
    logic [3:0] d0    = '0;
    logic [3:0] d1    = '0;
    logic [7:0] d2    = '0;
    logic [2:0] rdy, so, sov, sol, bsy;

    int n_cmp = 0;
    int n_bad = 0;

    piso_stream #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb4 (
        .Clock(clk), .Clear(Clear), .Load(ld[0]), .Data_In(d0), .Ready(rdy[0]),
        .Shift_En(en[0]), .SO(so[0]), .SO_Valid(sov[0]), .SO_Last(sol[0]), .Busy(bsy[0]));

    piso_stream #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb4 (
        .Clock(clk), .Clear(Clear), .Load(ld[1]), .Data_In(d1), .Ready(rdy[1]),
        .Shift_En(en[1]), .SO(so[1]), .SO_Valid(sov[1]), .SO_Last(sol[1]), .Busy(bsy[1]));

    piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
        .Clock(clk), .Clear(Clear), .Load(ld[2]), .Data_In(d2), .Ready(rdy[2]),
        .Shift_En(en[2]), .SO(so[2]), .SO_Valid(sov[2]), .SO_Last(sol[2]), .Busy(bsy[2]));

    // Model: up to two words owned by each instance (shifting + buffered), pos = bits taken of the head word.
    int          qn  [3] = '{0, 0, 0};
    int          pos [3] = '{0, 0, 0};
    logic [31:0] q0  [3] = '{0, 0, 0};
    logic [31:0] q1  [3] = '{0, 0, 0};

    function automatic int wd_of(input int i);
        return (i == 2) ? 8 : 4;
    endfunction

    function automatic bit msb_of(input int i);
        return (i == 1);
    endfunction

    function automatic logic [31:0] din_of(input int i);
        if (i == 0) return 32'(d0);
        if (i == 1) return 32'(d1);
        return 32'(d2);
    endfunction

    function automatic logic exp_so(input int i);
        int b;
        if (qn[i] == 0) return 1'b0;
        b = msb_of(i) ? (wd_of(i) - 1 - pos[i]) : pos[i];
        return q0[i][b];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            qn[i]  = 0;
            pos[i] = 0;
        end
    endfunction

    function automatic void model_step();
        for (int i = 0; i < 3; i++) begin
            bit acc;
            acc = ld[i] && (qn[i] < 2);
            if (qn[i] > 0 && en[i]) begin
                pos[i]++;
                if (pos[i] == wd_of(i)) begin
                    pos[i] = 0;
                    q0[i]  = q1[i];
                    qn[i]--;
                end
            end
            if (acc) begin
                if (qn[i] == 0) q0[i] = din_of(i);
                else            q1[i] = din_of(i);
                qn[i]++;
            end
        end
    endfunction

    function automatic void check(input string nm, input int i,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, i, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check("so",    i, 32'(so[i]),  32'(exp_so(i)));
            check("valid", i, 32'(sov[i]), 32'(qn[i] > 0));
            check("last",  i, 32'(sol[i]), 32'(qn[i] > 0 && pos[i] == wd_of(i) - 1));
            check("ready", i, 32'(rdy[i]), 32'(qn[i] < 2));
            check("busy",  i, 32'(bsy[i]), 32'(qn[i] > 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!Clear) model_step();
        @(negedge clk);
        #1;
    endtask

    logic [0:3] sb = 4'b1001;
    logic [0:7] sc = 8'b01101001;
    logic [0:6] sd = 7'b0110101;
    logic [0:3] se = 4'b1000;

    initial begin
        int sent, got, nb;
        logic [7:0] exp_q[$];
        logic [7:0] asm;
        logic cap, cbit, clast;

        // Reset held from time zero, released mid-cycle.
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_valid", i, 32'(sov[i]), 0);
            check("rst_ready", i, 32'(rdy[i]), 1);
            check("rst_busy",  i, 32'(bsy[i]), 0);
            check("rst_so",    i, 32'(so[i]),  0);
        end
        repeat (3) tick();
        Clear = 1'b0;
        repeat (2) tick();
        check("idle_valid", 0, 32'(sov[0]), 0);

        // Single LSB-first word.
        d0 = 4'b1001; ld[0] = 1'b1; en[0] = 1'b1;
        tick();
        ld[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("b_so",    0, 32'(so[0]),  32'(sb[k]));
            check("b_last",  0, 32'(sol[0]), 32'(k == 3));
            check("b_valid", 0, 32'(sov[0]), 1);
            tick();
        end
        check("b_idle", 0, 32'(sov[0]), 0);
        check("b_busy", 0, 32'(bsy[0]), 0);

        // Two MSB-first words back to back.
        en[1] = 1'b1; d1 = 4'b0110; ld[1] = 1'b1;
        tick();
        check("c_so", 1, 32'(so[1]), 32'(sc[0]));
        d1 = 4'b1001;
        tick();
        ld[1] = 1'b0;
        check("c_ready", 1, 32'(rdy[1]), 0);
        for (int k = 1; k < 8; k++) begin
            check("c_so",    1, 32'(so[1]),  32'(sc[k]));
            check("c_last",  1, 32'(sol[1]), 32'(k == 3 || k == 7));
            check("c_valid", 1, 32'(sov[1]), 1);
            tick();
        end
        check("c_idle", 1, 32'(sov[1]), 0);

        // Backpressure with a second word buffered during the stall.
        d0 = 4'b1100; ld[0] = 1'b1; en[0] = 1'b1;
        tick();
        ld[0] = 1'b0; en[0] = 1'b0;
        check("d_so0", 0, 32'(so[0]), 0);
        for (int s = 0; s < 5; s++) begin
            ld[0] = (s == 1);
            d0 = 4'b1010;
            tick();
            check("d_hold_so",   0, 32'(so[0]),  0);
            check("d_hold_last", 0, 32'(sol[0]), 0);
        end
        ld[0] = 1'b0;
        check("d_ready", 0, 32'(rdy[0]), 0);
        en[0] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("d_so", 0, 32'(so[0]), 32'(sd[k]));
        end
        tick();
        check("d_idle", 0, 32'(sov[0]), 0);

        // Clear mid-word with the buffer full.
        d0 = 4'b0101; ld[0] = 1'b1;
        tick();
        d0 = 4'b1111;
        tick();
        ld[0] = 1'b0;
        check("e_full", 0, 32'(rdy[0]), 0);
        Clear = 1'b1;
        model_clear();
        #1;
        check("e_valid", 0, 32'(sov[0]), 0);
        check("e_ready", 0, 32'(rdy[0]), 1);
        check("e_busy",  0, 32'(bsy[0]), 0);
        tick();
        Clear = 1'b0;
        repeat (3) begin
            tick();
            check("e_quiet", 0, 32'(sov[0]), 0);
        end
        d0 = 4'b0001; ld[0] = 1'b1;
        tick();
        ld[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("e_so", 0, 32'(so[0]), 32'(se[k]));
            tick();
        end
        check("e_idle", 0, 32'(sov[0]), 0);
        en[0] = 1'b0;

        // 8-bit random regression with stalls, reassembled word by word.
        sent = 0; got = 0; nb = 0; asm = '0;
        for (int c = 0; c < 4000 && got < 16; c++) begin
            ld[2] = (sent < 16) && ($urandom_range(0, 2) != 0);
            d2    = 8'($urandom);
            en[2] = ($urandom_range(0, 3) != 0);
            if (ld[2] && qn[2] < 2) begin
                exp_q.push_back(d2);
                sent++;
            end
            cap   = sov[2] && en[2];
            cbit  = so[2];
            clast = sol[2];
            tick();
            if (cap) begin
                asm[nb] = cbit;
                check("f_last", 2, 32'(clast), 32'(nb == 7));
                nb++;
                if (nb == 8) begin
                    if (exp_q.size() == 0) check("f_extra", 2, 32'(asm), 32'hFFFF_FFFF);
                    else                   check("f_word",  2, 32'(asm), 32'(exp_q.pop_front()));
                    got++;
                    nb = 0;
                end
            end
        end
        ld[2] = 1'b0; en[2] = 1'b0;
        check("f_count", 2, 32'(got), 16);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
